sm4_axis_arb2: RTL

- Packet-level arbiter and configuration sequencer in front of sm4_top_eth_support.
- Shares one byte-stream SM4 engine between two AXI-Stream requesters; each requester supplies its own key and enc/dec select.
- Grants whole packets round-robin and reprograms the engine (sm4_vld/sm4_key/sm4_sel) only between packets, and only when the winning requester's key/sel differs from the last programmed setting.
- The engine has no tready, so this block is the only back-pressure point.

---
 rtl/sm4_axis_arb2.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sm4_axis_arb2.sv
// Two-requester packet arbiter and key/mode sequencer for a shared byte-stream SM4 engine.
// Grants whole packets round-robin and reprograms the engine only between packets when needed.
module sm4_axis_arb2 #(
  parameter int unsigned TUSER_W = 8,
  parameter int unsigned CFG_GAP = 4
) (
  input  logic               clk,
  input  logic               rst,

  input  logic [7:0]         s0_axis_tdata,
  input  logic               s0_axis_tvalid,
  output logic               s0_axis_tready,
  input  logic               s0_axis_tlast,
  input  logic [TUSER_W-1:0] s0_axis_tuser,
  input  logic [127:0]       s0_key,
  input  logic               s0_sel,

  input  logic [7:0]         s1_axis_tdata,
  input  logic               s1_axis_tvalid,
  output logic               s1_axis_tready,
  input  logic               s1_axis_tlast,
  input  logic [TUSER_W-1:0] s1_axis_tuser,
  input  logic [127:0]       s1_key,
  input  logic               s1_sel,

  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  output logic [TUSER_W-1:0] m_axis_tuser,

  output logic               sm4_vld,
  output logic [127:0]       sm4_key,
  output logic               sm4_sel,
  output logic               grant_src
);

  typedef enum logic [1:0] {StIdle, StCfg, StSettle, StXfer} state_e;

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 ptr_q, ptr_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic [127:0]         key_q, key_d;
  logic                 sel_q, sel_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [TUSER_W-1:0]   tuser_q, tuser_d;

  logic                 req_any;
  logic                 req_port;
  logic [127:0]         req_key;
  logic                 req_sel;
  logic [7:0]           g_tdata;
  logic                 g_tvalid;
  logic                 g_tlast;
  logic [TUSER_W-1:0]   g_tuser;
  logic                 in_xfer;
  logic                 beat;

  // Contention resolved by the pointer; a lone requester always wins.
  always_comb begin
    req_any  = s0_axis_tvalid | s1_axis_tvalid;
    req_port = (s0_axis_tvalid && s1_axis_tvalid) ? ptr_q : s1_axis_tvalid;
    req_key  = req_port ? s1_key : s0_key;
    req_sel  = req_port ? s1_sel : s0_sel;
  end

  always_comb begin
    g_tdata  = grant_q ? s1_axis_tdata  : s0_axis_tdata;
    g_tvalid = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    g_tlast  = grant_q ? s1_axis_tlast  : s0_axis_tlast;
    g_tuser  = grant_q ? s1_axis_tuser  : s0_axis_tuser;
    in_xfer  = (state_q == StXfer);
    beat     = in_xfer && g_tvalid;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cfg_valid_d = cfg_valid_q;
    key_d       = key_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          grant_d = req_port;
          if (cfg_valid_q && (req_key == key_q) && (req_sel == sel_q)) begin
            state_d = StXfer;
          end else begin
            // Capture key/sel now so they are stable during the strobe cycle.
            key_d   = req_key;
            sel_d   = req_sel;
            state_d = StCfg;
          end
        end
      end
      StCfg: begin
        cfg_valid_d = 1'b1;
        cnt_d       = 8'(CFG_GAP);
        state_d     = StSettle;
      end
      StSettle: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = StXfer;
      end
      StXfer: begin
        if (beat && g_tlast) begin
          ptr_d   = ~grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tvalid_d = beat;
    tlast_d  = beat & g_tlast;
    tdata_d  = beat ? g_tdata : tdata_q;
    tuser_d  = beat ? g_tuser : tuser_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      ptr_q       <= 1'b0;
      cfg_valid_q <= 1'b0;
      key_q       <= '0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cfg_valid_q <= cfg_valid_d;
      key_q       <= key_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
    end
  end

  assign s0_axis_tready = in_xfer && !grant_q;
  assign s1_axis_tready = in_xfer && grant_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tuser   = tuser_q;
  assign sm4_vld        = (state_q == StCfg);
  assign sm4_key        = key_q;
  assign sm4_sel        = sel_q;
  assign grant_src      = grant_q;

endmodule
